seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the combinational ALU. Adds registered outputs, a start/done handshake and iterative multiply/divide. It sits between the decode stage and write-back in the multi-cycle core. Single-cycle ops complete in one clock; MUL/DIVU/REMU occupy the unit for WIDTH+1 clocks.

## Interface
- WIDTH, 32: operand/result width in bits, ≥ 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST_n  in  1  reset; asynchronous, active-low.
- iStart  in  1  request; sampled only in IDLE or DONE.
- iControl  in  5  operation code, using the ALU_* codes from params.v: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL, ALU_DIVU, ALU_REMU.
- iA  in  WIDTH  operand A; signed for SLT.
- iB  in  WIDTH  operand B; signed for SLT.
- oResult  out  WIDTH  registered result; holds until the next completion.
- oZero  out  1  registered; equals ~|oResult.
- oBusy  out  1  high while in RUN.
- oDone  out  1  one-cycle pulse; oResult is valid in that cycle.

## Operation
- FSM states:
  - IDLE: waits for iStart.
  - RUN: iterative ops only.
  - DONE: one cycle, then returns to IDLE.
- Operands and opcode are latched on the accepting edge. Later changes on iA/iB/iControl have no effect.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, default): IDLE/DONE → DONE, with oResult written on the same edge.
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT gives {WIDTH-1 zeros, signed A<B}.
  - Any undefined code gives oResult = iA.
- ALU_MUL: shift-add over WIDTH iterations. oResult is the low WIDTH bits of A*B; this is identical for signed and unsigned operands.
- ALU_DIVU / ALU_REMU: restoring unsigned division over WIDTH iterations, one quotient bit per cycle. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero is not special-cased in control flow and yields:
  - DIVU: all ones.
  - REMU: A.
- RUN: the counter loads WIDTH on entry and decrements each cycle. At count 1, the final iteration writes oResult and the FSM goes to DONE.
- iStart in RUN is ignored; no queueing.
- iStart in DONE is accepted, giving back-to-back operation with no IDLE gap.
- oResult/oZero change only on entry to DONE. Between completions they hold their last value.

## Timing
- Reset values: state IDLE, oResult 0, oZero 1, oBusy 0, oDone 0, counter 0, internal operand/accumulator registers 0.
- Reset asserted mid-RUN aborts the op immediately (asynchronously). No oDone is produced for the aborted op.
- Let the accepting edge be edge 0.
- Single-cycle op: oDone high in cycle 1 (after edge 0), result valid at that point. Latency 1.
- Iterative op: oBusy high in cycles 1..WIDTH; oDone high in cycle WIDTH+1. Latency WIDTH+1.
- Throughput:
  - One single-cycle op per clock with iStart held high.
  - One iterative op per WIDTH+1 clocks.
- oBusy and oDone are never high together.

## Configuration
- ALU_MULDIV_EN defined: MUL/DIVU/REMU are implemented as above, including the RUN state, counter and iteration datapath.
- ALU_MULDIV_EN undefined:
  - ALU_MUL/ALU_DIVU/ALU_REMU fall to the default (oResult = iA, latency 1).
  - The RUN state and datapath are removed and oBusy is tied to 0.

## Test plan
- Reset with inputs driven, then release → oResult 0, oZero 1, oBusy 0, oDone 0. Pulse iStart with ADD, A=0xFFFFFFFF, B=1 → oDone in cycle 1, oResult 0, oZero 1.
- iStart held high with SLT A=-1, B=1; then SUB A=5, B=7 on the next cycle → consecutive oDone pulses; results 1 then 0xFFFFFFFE.
- MUL A=0xFFFFFFFF (-1), B=3 → oBusy for 32 cycles, oDone in cycle 33, oResult 0xFFFFFFFD. An iStart issued during busy is ignored.
- DIVU A=100, B=7 → oResult 14. REMU same operands → oResult 2. DIVU A=9, B=0 → 0xFFFFFFFF; REMU A=9, B=0 → 9.
- Start MUL, then deassert iRST_n at cycle 10 → outputs return to reset values immediately; no oDone follows. An ADD after release completes normally.
- Build without ALU_MULDIV_EN: MUL A=6, B=7 → oDone in cycle 1, oResult 6, oBusy never high.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU with registered outputs, start/done handshake and iterative MUL/DIVU/REMU.
// Optional feature macro: ALU_MULDIV_EN (iterative multiply/divide and the RUN state).
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iStart,
    input  logic [4:0]       iControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic [WIDTH-1:0] oResult,
    output logic             oZero,
    output logic             oBusy,
    output logic             oDone
);

    localparam logic [4:0] ALU_AND  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd6;
    localparam logic [4:0] ALU_SLT  = 5'd7;
`ifdef ALU_MULDIV_EN
    localparam logic [4:0] ALU_MUL  = 5'd8;
    localparam logic [4:0] ALU_DIVU = 5'd9;
    localparam logic [4:0] ALU_REMU = 5'd10;
    localparam int unsigned CNT_W   = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
`else
    typedef enum logic {S_IDLE, S_DONE} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_res;

`ifdef ALU_MULDIV_EN
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    // acc: product accumulator (MUL) or partial remainder (DIV/REM)
    // opa: shifting multiplicand (MUL) or dividend-in / quotient-out (DIV/REM)
    // opb: shifting multiplier (MUL) or divisor (DIV/REM)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             is_iter;
    logic [WIDTH-1:0] iter_res;

    assign is_iter = (iControl == ALU_MUL) || (iControl == ALU_DIVU) || (iControl == ALU_REMU);
`endif

    always_comb begin
        case (iControl)
            ALU_AND: alu_res = iA & iB;
            ALU_OR:  alu_res = iA | iB;
            ALU_ADD: alu_res = iA + iB;
            ALU_SUB: alu_res = iA - iB;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(iA) < $signed(iB))};
            default: alu_res = iA;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifdef ALU_MULDIV_EN
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_sh   = '0;
        diff     = '0;
        iter_res = '0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (iStart) begin
`ifdef ALU_MULDIV_EN
                    if (is_iter) begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(WIDTH);
                        op_d    = iControl;
                        acc_d   = '0;
                        opa_d   = iA;
                        opb_d   = iB;
                    end else
`endif
                    begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = alu_res;
                        zero_d   = ~|alu_res;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q == ALU_MUL) begin
                    acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    // A zero divisor never borrows: quotient fills with ones, remainder ends as A
                    rem_sh = {acc_q, opa_q[WIDTH-1]};
                    diff   = rem_sh - {1'b0, opb_q};
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        opa_d = {opa_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        opa_d = {opa_q[WIDTH-2:0], 1'b0};
                    end
                end
                if (cnt_q == CNT_W'(1)) begin
                    iter_res = (op_q == ALU_DIVU) ? opa_d : acc_d;
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = iter_res;
                    zero_d   = ~|iter_res;
                end
            end
            default: state_d = S_IDLE;
`endif
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifdef ALU_MULDIV_EN
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
`endif
        end
    end

    assign oResult = result_q;
    assign oZero   = zero_q;
    assign oDone   = done_q;
`ifdef ALU_MULDIV_EN
    assign oBusy   = busy_q;
`else
    assign oBusy   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an arithmetic reference model.
// Follows the ALU_MULDIV_EN macro so either build of the design can be checked.
module tb_seq_alu;

    localparam int unsigned W = 32;
    localparam logic [4:0] ALU_AND  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd6;
    localparam logic [4:0] ALU_SLT  = 5'd7;
    localparam logic [4:0] ALU_MUL  = 5'd8;
    localparam logic [4:0] ALU_DIVU = 5'd9;
    localparam logic [4:0] ALU_REMU = 5'd10;
`ifdef ALU_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    logic         iCLK = 1'b0;
    logic         iRST_n = 1'b1;
    logic         iStart = 1'b0;
    logic [4:0]   iControl = '0;
    logic [W-1:0] iA = '0;
    logic [W-1:0] iB = '0;
    logic [W-1:0] oResult;
    logic         oZero;
    logic         oBusy;
    logic         oDone;

    seq_alu #(.WIDTH(W)) dut (
        .iCLK    (iCLK),
        .iRST_n  (iRST_n),
        .iStart  (iStart),
        .iControl(iControl),
        .iA      (iA),
        .iB      (iB),
        .oResult (oResult),
        .oZero   (oZero),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 iCLK = ~iCLK;

    int unsigned  n_tests = 0;
    int unsigned  n_fail = 0;
    int unsigned  both_high = 0;
    int unsigned  busy_seen = 0;
    int unsigned  busy_exp = 0;
    logic [W-1:0] prev_res = '0;

    always @(negedge iCLK) begin
        if (oBusy && oDone) both_high++;
        if (oBusy) busy_seen++;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] ones;
        ones = '1;
        case (op)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            ALU_MUL:  return MULDIV_EN ? a * b : a;
            ALU_DIVU: return MULDIV_EN ? ((b == 0) ? ones : a / b) : a;
            ALU_REMU: return MULDIV_EN ? ((b == 0) ? a : a % b) : a;
            default:  return a;
        endcase
    endfunction

    function automatic int unsigned latency(input logic [4:0] op);
        return (MULDIV_EN && (op == ALU_MUL || op == ALU_DIVU || op == ALU_REMU)) ? W + 1 : 1;
    endfunction

    // Called just after a falling edge; returns at the falling edge of the done cycle.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke);
        int unsigned  lat;
        logic [W-1:0] exp;
        lat = latency(op);
        exp = model(op, a, b);
        busy_exp += lat - 1;
        iStart = 1'b1;
        iControl = op;
        iA = a;
        iB = b;
        for (int unsigned c = 1; c <= lat; c++) begin
            @(negedge iCLK);
            if (c == 1) begin
                iStart = 1'b0;
                iControl = 5'($urandom);
                iA = $urandom;
                iB = $urandom;
            end
            if (c < lat) begin
                check({tag, "_busy"}, W'(oBusy), W'(1));
                check({tag, "_early_done"}, W'(oDone), W'(0));
                check({tag, "_hold"}, oResult, prev_res);
            end else begin
                check({tag, "_done"}, W'(oDone), W'(1));
                check({tag, "_busy_at_done"}, W'(oBusy), W'(0));
                check({tag, "_result"}, oResult, exp);
                check({tag, "_zero"}, W'(oZero), W'(exp == 0));
            end
            if (poke && lat > 6) begin
                if (c == 3) begin
                    iStart = 1'b1;
                    iControl = ALU_ADD;
                end else if (c == 4) begin
                    iStart = 1'b0;
                end
            end
        end
        prev_res = exp;
    endtask

    task automatic idle(input int unsigned n);
        iStart = 1'b0;
        repeat (n) @(negedge iCLK);
    endtask

    initial begin
        logic [4:0]   codes[8];
        logic [4:0]   op;
        logic [W-1:0] a, b;
        int unsigned  dones;
        codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL, ALU_DIVU, ALU_REMU};

        // reset while inputs request work
        #2 iRST_n = 1'b0;
        iStart = 1'b1;
        iControl = ALU_ADD;
        iA = 32'd5;
        iB = 32'd6;
        repeat (3) @(negedge iCLK);
        check("rst_result", oResult, '0);
        check("rst_done", W'(oDone), W'(0));
        iStart = 1'b0;
        iRST_n = 1'b1;
        @(negedge iCLK);
        check("post_rst_result", oResult, '0);
        check("post_rst_zero", W'(oZero), W'(1));
        check("post_rst_busy", W'(oBusy), W'(0));
        check("post_rst_done", W'(oDone), W'(0));

        run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        idle(1);

        // back-to-back single-cycle ops with iStart held high
        run_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("sub_neg", ALU_SUB, 32'd5, 32'd7, 1'b0);
        @(negedge iCLK);
        check("after_b2b_done", W'(oDone), W'(0));
        check("after_b2b_hold", oResult, prev_res);

        run_op("mul_neg", ALU_MUL, 32'hFFFF_FFFF, 32'd3, 1'b1);
        run_op("mul_6x7", ALU_MUL, 32'd6, 32'd7, 1'b0);
        idle(1);
        run_op("divu", ALU_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("remu", ALU_REMU, 32'd100, 32'd7, 1'b0);
        run_op("divu_by0", ALU_DIVU, 32'd9, 32'd0, 1'b0);
        run_op("remu_by0", ALU_REMU, 32'd9, 32'd0, 1'b0);
        idle(2);

        // asynchronous reset in the middle of a multiply
        iStart = 1'b1;
        iControl = ALU_MUL;
        iA = 32'd12345;
        iB = 32'd678;
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (9) @(negedge iCLK);
        busy_exp += MULDIV_EN ? 10 : 0;
        #2 iRST_n = 1'b0;
        #1;
        check("abort_result", oResult, '0);
        check("abort_zero", W'(oZero), W'(1));
        check("abort_busy", W'(oBusy), W'(0));
        check("abort_done", W'(oDone), W'(0));
        @(negedge iCLK);
        iRST_n = 1'b1;
        prev_res = '0;
        dones = 0;
        repeat (W + 5) begin
            @(negedge iCLK);
            if (oDone) dones++;
        end
        check("abort_no_done", W'(dones), W'(0));
        run_op("add_after_abort", ALU_ADD, 32'd2, 32'd3, 1'b0);

        for (int unsigned i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 7)] : 5'($urandom);
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op("rand", op, a, b, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        check("busy_and_done_overlap", W'(both_high), W'(0));
        check("busy_cycle_total", W'(busy_seen), W'(busy_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
